// File: rtl/uacm_reg_responder.sv
// rtl/uacm_reg_responder.sv - byte-stream read/write command responder driving a 32-bit register bus
module uacm_reg_responder #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  out_data,
    input  logic        out_last,
    input  logic        out_valid,
    output logic        out_ready,
    output logic [7:0]  in_data,
    output logic        in_last,
    output logic        in_valid,
    input  logic        in_ready,
    output logic        in_flush_now,
    output logic [7:0]  bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    output logic        bus_cyc,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP
    } state_t;

    localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

    state_t       state_q, state_d;
    logic [1:0]   wcnt;
    logic [15:0]  tcnt;
    logic [39:0]  resp_sr;
    logic [2:0]   rcnt;
    logic         op_known;
    logic         unused_ok;

    assign unused_ok = out_last;
    assign op_known  = (out_data == 8'h01) || (out_data == 8'h02);

    always_comb begin
        state_d      = state_q;
        out_ready    = 1'b0;
        in_valid     = 1'b0;
        bus_cyc      = 1'b0;
        in_data      = 8'h00;
        in_last      = 1'b0;
        in_flush_now = 1'b0;
        case (state_q)
            S_IDLE: begin
                out_ready = 1'b1;
                if (out_valid) state_d = op_known ? S_ADDR : S_RESP;
            end
            S_ADDR: begin
                out_ready = 1'b1;
                if (out_valid) state_d = bus_we ? S_DATA : S_BUS;
            end
            S_DATA: begin
                out_ready = 1'b1;
                if (out_valid && wcnt == 2'd3) state_d = S_BUS;
            end
            S_BUS: begin
                bus_cyc = 1'b1;
                if (bus_ack || tcnt == TLAST) state_d = S_RESP;
            end
            S_RESP: begin
                in_valid     = 1'b1;
                in_data      = resp_sr[39:32];
                in_last      = (rcnt == 3'd1);
                in_flush_now = in_last;
                if (in_ready && rcnt == 3'd1) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            bus_addr  <= 8'h00;
            bus_wdata <= 32'h0;
            bus_we    <= 1'b0;
            wcnt      <= 2'd0;
            tcnt      <= 16'd0;
            resp_sr   <= 40'h0;
            rcnt      <= 3'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (out_valid) begin
                        if (op_known) begin
                            bus_we <= (out_data == 8'h01);
                        end else begin
                            resp_sr <= {8'hFF, 32'h0};
                            rcnt    <= 3'd1;
                        end
                    end
                end
                S_ADDR: begin
                    if (out_valid) begin
                        bus_addr <= out_data;
                        wcnt     <= 2'd0;
                        tcnt     <= 16'd0;
                    end
                end
                S_DATA: begin
                    if (out_valid) begin
                        bus_wdata <= {bus_wdata[23:0], out_data};
                        wcnt      <= wcnt + 2'd1;
                        tcnt      <= 16'd0;
                    end
                end
                S_BUS: begin
                    // Ack wins over a timeout landing in the same cycle; the counter never passes TLAST.
                    if (bus_ack) begin
                        if (bus_we) begin
                            resp_sr <= {8'h81, 32'h0};
                            rcnt    <= 3'd1;
                        end else begin
                            resp_sr <= {8'h82, bus_rdata};
                            rcnt    <= 3'd5;
                        end
                    end else if (tcnt == TLAST) begin
                        resp_sr <= {8'hFE, 32'h0};
                        rcnt    <= 3'd1;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                S_RESP: begin
                    if (in_ready) begin
                        resp_sr <= {resp_sr[31:0], 8'h00};
                        rcnt    <= rcnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uacm_reg_responder.sv
// tb/tb_uacm_reg_responder.sv - scoreboard bench for uacm_reg_responder
module tb_uacm_reg_responder;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_valid;
    logic        in_ready = 1'b1;
    logic        in_flush_now;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic        bus_cyc;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } rbyte_t;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          len;
    } btxn_t;

    rbyte_t rq[$];
    btxn_t  bq[$];
    rbyte_t re;
    btxn_t  cur;

    bit   ack_en     = 1'b1;
    int   ack_delay  = 0;
    bit   rand_ready = 1'b0;
    int   cyc_len    = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic prev_last;

    uacm_reg_responder #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .in_flush_now(in_flush_now),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_cyc(bus_cyc),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        in_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Response side: pop the scoreboard on every accepted byte, and hold stalled bytes to their values.
    always @(negedge clk) begin
        if (rst) begin
            if (out_ready && in_valid) check("ready_valid_overlap", 1, 0);
            if (in_valid) check("flush_now", in_flush_now, in_last);
            if (prev_stall) begin
                check("stall_valid", in_valid, 1);
                check("stall_data", in_data, prev_data);
                check("stall_last", in_last, prev_last);
            end
            if (in_valid && in_ready) begin
                if (rq.size() == 0) begin
                    check("unexpected_resp", 1, 0);
                end else begin
                    re = rq.pop_front();
                    check("resp_data", in_data, re.data);
                    check("resp_last", in_last, re.last);
                end
            end
            prev_stall = in_valid && !in_ready;
            prev_data  = in_data;
            prev_last  = in_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Bus slave model: checks each request, acks after ack_delay cycles, times the cyc pulse.
    always @(negedge clk) begin
        if (bus_cyc) begin
            if (cyc_len == 0) begin
                if (bq.size() == 0) begin
                    check("unexpected_bus", 1, 0);
                    cur = '{1'b0, 8'h00, 32'h0, 0};
                end else begin
                    cur = bq.pop_front();
                    check("bus_we", bus_we, cur.we);
                    check("bus_addr", bus_addr, cur.addr);
                    if (cur.we) check("bus_wdata", bus_wdata, cur.wdata);
                end
            end
            cyc_len++;
            bus_ack = ack_en && (cyc_len == ack_delay + 1);
        end else begin
            if (cyc_len != 0) begin
                check("cyc_len", cyc_len, cur.len);
                check("turnaround_valid", in_valid, 1);
                cyc_len = 0;
            end
            bus_ack = 1'b0;
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        int n = 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        out_valid = 1'b1;
        out_data  = b;
        forever begin
            @(negedge clk);
            if (out_ready) break;
            n++;
            if (n > 200) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        out_valid = 1'b0;
    endtask

    task automatic push_resp(input logic [7:0] d, input logic l);
        rbyte_t r;
        r.data = d;
        r.last = l;
        rq.push_back(r);
    endtask

    task automatic push_bus(input logic we, input logic [7:0] a, input logic [31:0] wd);
        btxn_t t;
        t.we    = we;
        t.addr  = a;
        t.wdata = wd;
        t.len   = ack_en ? ack_delay + 1 : TMO;
        bq.push_back(t);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input int gmax);
        logic [7:0] cmd [6];
        cmd = '{8'h01, a, d[31:24], d[23:16], d[15:8], d[7:0]};
        push_bus(1'b1, a, d);
        push_resp(ack_en ? 8'h81 : 8'hFE, 1'b1);
        for (int i = 0; i < 6; i++) send(cmd[i], $urandom_range(0, gmax));
        check("wr_cyc_next", bus_cyc, 1);
        check("wr_ready_low", out_ready, 0);
    endtask

    task automatic do_read(input logic [7:0] a, input int gmax);
        push_bus(1'b0, a, 32'h0);
        if (ack_en) begin
            push_resp(8'h82, 1'b0);
            push_resp(bus_rdata[31:24], 1'b0);
            push_resp(bus_rdata[23:16], 1'b0);
            push_resp(bus_rdata[15:8], 1'b0);
            push_resp(bus_rdata[7:0], 1'b1);
        end else begin
            push_resp(8'hFE, 1'b1);
        end
        send(8'h02, $urandom_range(0, gmax));
        send(a, $urandom_range(0, gmax));
        check("rd_cyc_next", bus_cyc, 1);
        check("rd_ready_low", out_ready, 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() != 0 || bq.size() != 0 || cyc_len != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("drain_resp", rq.size(), 0);
        check("drain_bus", bq.size(), 0);
        @(posedge clk);
        #1;
        check("idle_ready", out_ready, 1);
        check("idle_valid", in_valid, 0);
    endtask

    task automatic check_reset();
        check("rst_out_ready", out_ready, 1);
        check("rst_in_valid", in_valid, 0);
        check("rst_in_last", in_last, 0);
        check("rst_flush", in_flush_now, 0);
        check("rst_in_data", in_data, 8'h00);
        check("rst_bus_cyc", bus_cyc, 0);
        check("rst_bus_we", bus_we, 0);
        check("rst_bus_addr", bus_addr, 8'h00);
        check("rst_bus_wdata", bus_wdata, 32'h0);
    endtask

    initial begin
        rst       = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_last  = 1'b0;
        bus_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        rst = 1'b1;

        ack_en    = 1'b1;
        ack_delay = 2;
        do_write(8'h10, 32'hDEADBEEF, 0);
        drain();

        ack_delay = 0;
        bus_rdata = 32'h12345678;
        do_read(8'h20, 0);
        drain();

        ack_en = 1'b0;
        do_read(8'h05, 0);
        drain();
        ack_en    = 1'b1;
        bus_rdata = 32'hCAFEF00D;
        do_read(8'h05, 0);
        drain();

        push_resp(8'hFF, 1'b1);
        send(8'h7A, 0);
        check("unk_valid", in_valid, 1);
        check("unk_data", in_data, 8'hFF);
        check("unk_last", in_last, 1);
        check("unk_no_cyc", bus_cyc, 0);
        bus_rdata = 32'hA5A55A5A;
        do_read(8'h33, 0);
        drain();

        rand_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_rdata = $urandom;
            ack_delay = $urandom_range(0, 3);
            do_read(8'($urandom_range(0, 255)), 3);
            do_write(8'($urandom_range(0, 255)), $urandom, 3);
            drain();
        end
        rand_ready = 1'b0;
        ack_delay  = 0;

        send(8'h01, 0);
        send(8'h10, 0);
        send(8'hDE, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset();
        rst       = 1'b1;
        bus_rdata = 32'h0BADF00D;
        do_read(8'h10, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uacm_reg_responder.md
# uacm_reg_responder

Byte-stream command responder on the user side of the muacm pipe pair, in the user clock domain behind the clock-crossing stage. It consumes host-to-device bytes from the OUT pipe and parses fixed-format read and write commands. It runs single-beat transactions on a simple 32-bit register bus and returns status/data bytes on the IN pipe. On the final byte of each response it raises last and flush_now, so the host sees the reply without waiting for the flush timeout.

## Interface
- `TIMEOUT`, default 255: bus cycles to wait for `bus_ack` before aborting; range 1..65535.
- `clk`  in  1: user clock. One clock domain; no internal crossings.
- `rst`  in  1: synchronous, active-low reset.
- `out_data`  in  8: command byte from the host (OUT pipe).
- `out_last`  in  1: ignored; framing comes from command length only.
- `out_valid`  in  1: command byte valid.
- `out_ready`  out  1: responder accepts the byte.
- `in_data`  out  8: response byte to the host (IN pipe).
- `in_last`  out  1: high on the final response byte.
- `in_valid`  out  1: response byte valid.
- `in_ready`  in  1: pipe accepts the byte.
- `in_flush_now`  out  1: equals `in_last & in_valid`.
- `bus_addr`  out  8: register address.
- `bus_wdata`  out  32: write data.
- `bus_we`  out  1: 1 = write, 0 = read; valid while `bus_cyc` is high.
- `bus_cyc`  out  1: transaction request, held until ack or timeout.
- `bus_ack`  in  1: single-cycle completion.
- `bus_rdata`  in  32: read data, sampled in the `bus_ack` cycle.

## Operation
- Command formats (bytes in order):
  - Write: 0x01, ADDR, D3, D2, D1, D0 (MSB first).
  - Read: 0x02, ADDR.
- Response formats:
  - Write OK: 0x81.
  - Read OK: 0x82, D3, D2, D1, D0.
  - Bus timeout: 0xFE.
  - Unknown opcode: 0xFF, sent immediately; the ADDR byte is not consumed.
- States:
  - IDLE: waits for the opcode. 0x01 or 0x02 -> ADDR. Any other value -> RESP carrying 0xFF.
  - ADDR: latches `bus_addr`. Read -> BUS. Write -> DATA.
  - DATA: shifts 4 bytes into `bus_wdata` from MSB to LSB. A 2-bit counter reaching 3 on acceptance -> BUS.
  - BUS: `bus_cyc`=1 while the timeout counter runs.
    - `bus_ack` -> RESP with an OK frame; on a read, `bus_rdata` is captured into the response shift register.
    - Counter reaches `TIMEOUT` without ack -> RESP with 0xFE; `bus_cyc` drops.
  - RESP: presents bytes one at a time and advances on `in_valid & in_ready`. After the last byte is accepted -> IDLE.
- `out_ready` = 1 in IDLE, ADDR and DATA only. Once a command is in progress, bytes are never dropped or skipped.
- `in_valid` = 1 only in RESP. `in_data` and `in_last` hold stable while `in_valid & ~in_ready`.
- Timeout counter width is 16 bits. It clears on entry to BUS and does not wrap: it saturates at the timeout compare.
- `bus_ack` outside BUS is ignored. `bus_addr` and `bus_wdata` keep their last values when idle.

## Timing
- Reset (`rst`=0 at a `clk` edge), taking effect the next cycle:
  - State -> IDLE.
  - `out_ready`=1.
  - `in_valid`=0, `in_last`=0, `in_flush_now`=0, `in_data`=0x00.
  - `bus_cyc`=0, `bus_we`=0, `bus_addr`=0x00, `bus_wdata`=0.
- Reset mid-command or mid-response abandons the frame with no partial response. Reset with `bus_cyc` high drops it the next cycle.
- Final command byte accepted at edge N -> `bus_cyc`=1 from cycle N+1, and `out_ready`=0 from N+1.
- `bus_ack` sampled at edge M -> `bus_cyc`=0 and `in_valid`=1 with the first response byte from M+1. Turnaround is 1 cycle.
- Ack never arrives -> `bus_cyc` is high for exactly `TIMEOUT` cycles, then 0xFE is presented the next cycle.
- Unknown opcode accepted at N -> `in_valid`=1 with `in_data`=0xFF and `in_last`=1 at N+1.
- With `in_ready` held high, consecutive response bytes go out back-to-back, one per cycle.
- Last response byte accepted at edge K -> `in_valid`=0 and `out_ready`=1 from K+1.
- No cycle has both `out_ready` and `in_valid` high.

## Test plan
- Write: send 01 10 DE AD BE EF with `bus_ack` 2 cycles after `bus_cyc` -> one `bus_cyc` pulse with we=1, addr=0x10, wdata=0xDEADBEEF; response 81 with `in_last`=`in_flush_now`=1.
- Read: send 02 20 with `bus_rdata`=0x12345678 and immediate ack -> response 82 12 34 56 78, `in_last` only on 0x78, first byte exactly 1 cycle after ack.
- Timeout: `TIMEOUT`=8, send 02 05 with no ack -> `bus_cyc` high for exactly 8 cycles, response FE with last; a following 02 05 with ack completes normally.
- Unknown opcode: send 7A 02 33 with ack -> FF, then 82 plus data; byte 0x7A produces no bus cycle.
- Backpressure: read with `in_ready` toggling randomly and `out_valid` gaps of 0-3 cycles -> bytes unchanged while stalled, order preserved, no duplicates, `out_ready` low throughout.
- Reset mid-DATA (after 01 10 DE): assert `rst`=0 for 1 cycle -> all outputs at reset values; then 02 10 yields exactly one read and a 5-byte response.
